data_memory_ctrl: RTL and testbench

//  Byte-addressed data memory for the pipelined CPU's MEM stage. It is parametrised in depth and access latency.

---
 rtl/data_memory_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory for the CPU MEM stage.
// Four byte lanes of storage, byte/half/word access with sign or zero
// extension, a req/ready handshake and a fixed response latency. Misaligned
// accesses are rejected with a flagged response instead of being performed.

// One byte lane of the word-organised memory array.
module dmem_lane #(
    parameter int IDX_BITS = 6
) (
    input  logic                i_clk,
    input  logic                i_we,
    input  logic [IDX_BITS-1:0] i_idx,
    input  logic [7:0]          i_wdata,
    output logic [7:0]          o_rdata
);
    logic [7:0] r_mem [0:(1<<IDX_BITS)-1];

    // Storage is never cleared; only an enabled store changes it.
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_idx] <= i_wdata;
    end

    assign o_rdata = r_mem[i_idx];
endmodule

module data_memory_ctrl #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_mem_write,
    input  logic [31:0] i_address,
    input  logic [31:0] i_write_data,
    input  logic [1:0]  i_mbyte,
    input  logic        i_unsigned,
    output logic        o_ready,
    output logic        o_resp_valid,
    output logic [31:0] o_read_data,
    output logic        o_misaligned
);
    localparam int NUM_LANES = 4;
    localparam int IDX_BITS  = ADDR_BITS - 2;
    localparam int CNT_W     = 4;
    localparam bit LAT1      = (LATENCY == 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                          r_state;
    logic [CNT_W-1:0]                r_cnt;
    logic [31:0]                     r_pend_data;
    logic                            r_pend_mis;

    logic [IDX_BITS-1:0]             w_idx;
    logic [1:0]                      w_lane_sel;
    logic                            w_is_word;
    logic                            w_is_half;
    logic                            w_is_byte;
    logic                            w_misaligned;
    logic                            w_accept;
    logic                            w_do_write;
    logic [NUM_LANES-1:0]            w_lane_we;
    logic [NUM_LANES-1:0][7:0]       w_lane_wd;
    logic [NUM_LANES-1:0][7:0]       w_rd_word;
    logic [7:0]                      w_byte;
    logic [15:0]                     w_half;
    logic [31:0]                     w_load_val;
    logic [31:0]                     w_resp_data;
    logic                            w_unused;

    // Address bits above the array size simply wrap.
    assign w_unused   = &{1'b0, i_address[31:ADDR_BITS]};
    assign w_idx      = i_address[ADDR_BITS-1:2];
    assign w_lane_sel = i_address[1:0];

    // MByte 11 behaves as a word access.
    assign w_is_word  = (i_mbyte == 2'b00) || (i_mbyte == 2'b11);
    assign w_is_half  = (i_mbyte == 2'b01);
    assign w_is_byte  = (i_mbyte == 2'b10);

    assign w_misaligned = (w_is_half && i_address[0]) ||
                          (w_is_word && (i_address[1:0] != 2'b00));

    // Inputs only matter on the cycle the controller is idle.
    assign w_accept   = (r_state == S_IDLE) && i_req;
    assign w_do_write = w_accept && i_mem_write && !w_misaligned;

    // Per-lane write enable/data steering and storage.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        localparam logic [1:0] LN = 2'(g);

        assign w_lane_we[g] = w_do_write &&
                              (w_is_word ||
                               (w_is_half && (w_lane_sel[1] == LN[1])) ||
                               (w_is_byte && (w_lane_sel == LN)));

        assign w_lane_wd[g] = w_is_word ? i_write_data[8*g +: 8] :
                              w_is_half ? (LN[0] ? i_write_data[15:8] : i_write_data[7:0]) :
                                          i_write_data[7:0];

        dmem_lane #(.IDX_BITS(IDX_BITS)) u_lane (
            .i_clk   (i_clk),
            .i_we    (w_lane_we[g]),
            .i_idx   (w_idx),
            .i_wdata (w_lane_wd[g]),
            .o_rdata (w_rd_word[g])
        );
    end

    // Right-align the addressed lane(s) of the read word and extend.
    always_comb begin
        w_byte     = w_rd_word[w_lane_sel];
        w_half     = w_lane_sel[1] ? {w_rd_word[3], w_rd_word[2]}
                                   : {w_rd_word[1], w_rd_word[0]};
        w_load_val = w_rd_word;
        if (w_is_byte)
            w_load_val = i_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
        else if (w_is_half)
            w_load_val = i_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
    end

    // Stores and rejected accesses always answer with zero data.
    assign w_resp_data = (i_mem_write || w_misaligned) ? 32'd0 : w_load_val;

    // Handshake FSM; the response is captured at acceptance so later stores
    // cannot disturb a load already in flight.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_pend_data  <= '0;
            r_pend_mis   <= 1'b0;
            o_ready      <= 1'b1;
            o_resp_valid <= 1'b0;
            o_read_data  <= '0;
            o_misaligned <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    o_resp_valid <= 1'b0;
                    o_read_data  <= '0;
                    o_misaligned <= 1'b0;
                    if (w_accept) begin
                        o_ready     <= 1'b0;
                        r_pend_data <= w_resp_data;
                        r_pend_mis  <= w_misaligned;
                        if (LAT1) begin
                            r_state      <= S_RESP;
                            o_resp_valid <= 1'b1;
                            o_read_data  <= w_resp_data;
                            o_misaligned <= w_misaligned;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state      <= S_RESP;
                        o_resp_valid <= 1'b1;
                        o_read_data  <= r_pend_data;
                        o_misaligned <= r_pend_mis;
                    end
                end
                S_RESP: begin
                    r_state      <= S_IDLE;
                    o_ready      <= 1'b1;
                    o_resp_valid <= 1'b0;
                    o_read_data  <= '0;
                    o_misaligned <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    o_ready      <= 1'b1;
                    o_resp_valid <= 1'b0;
                    o_read_data  <= '0;
                    o_misaligned <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: a LATENCY=2 instance and a
// LATENCY=1 instance sharing clock, reset and request fields.
module tb_data_memory_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, mw, un;
    logic [31:0] addr, wd;
    logic [1:0]  sz;
    logic        rdy0, rv0, mis0, rdy1, rv1, mis1;
    logic [31:0] rd0, rd1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          st;
        logic [31:0] a;
        logic [31:0] wd;
        logic [1:0]  sz;
        bit          un;
        logic [31:0] ed;
        bit          em;
    } vec_t;

    vec_t vt[$];
    vec_t vt1[$];

    always #5 clk = ~clk;

    data_memory_ctrl #(.ADDR_BITS(8), .LATENCY(2)) dut (
        .i_clk(clk), .i_reset(rst), .i_req(req0), .i_mem_write(mw),
        .i_address(addr), .i_write_data(wd), .i_mbyte(sz), .i_unsigned(un),
        .o_ready(rdy0), .o_resp_valid(rv0), .o_read_data(rd0), .o_misaligned(mis0)
    );

    data_memory_ctrl #(.ADDR_BITS(8), .LATENCY(1)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_req(req1), .i_mem_write(mw),
        .i_address(addr), .i_write_data(wd), .i_mbyte(sz), .i_unsigned(un),
        .o_ready(rdy1), .o_resp_valid(rv1), .o_read_data(rd1), .o_misaligned(mis1)
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endfunction

    // One complete access on instance w (0: LATENCY=2, 1: LATENCY=1).
    task automatic acc(input bit w, input vec_t v, input string nm);
        int k;
        bit got;
        int lat;
        lat = w ? 1 : 2;
        @(negedge clk);
        k = 0;
        while (!(w ? rdy1 : rdy0) && k < 32) begin
            @(negedge clk);
            k++;
        end
        chk({nm, " ready_before"}, 32'(w ? rdy1 : rdy0), 32'd1);
        mw = v.st; addr = v.a; wd = v.wd; sz = v.sz; un = v.un;
        if (w) req1 = 1'b1; else req0 = 1'b1;
        @(posedge clk);
        #1;
        req0 = 1'b0; req1 = 1'b0;
        mw = 1'b1; addr = 32'hFFFF_FFFF; wd = 32'h5A5A_5A5A; sz = 2'b10; un = 1'b0;
        k = 0;
        got = 1'b0;
        while (!got && k < 32) begin
            @(negedge clk);
            k++;
            got = w ? rv1 : rv0;
            if (!got) chk({nm, " ready_busy"}, 32'(w ? rdy1 : rdy0), 32'd0);
        end
        chk({nm, " latency"}, 32'(k), 32'(lat));
        chk({nm, " rdata"}, w ? rd1 : rd0, v.ed);
        chk({nm, " misaligned"}, 32'(w ? mis1 : mis0), 32'(v.em));
        chk({nm, " ready_at_resp"}, 32'(w ? rdy1 : rdy0), 32'd0);
        @(negedge clk);
        chk({nm, " ready_after"}, 32'(w ? rdy1 : rdy0), 32'd1);
        chk({nm, " resp_one_cycle"}, 32'(w ? rv1 : rv0), 32'd0);
    endtask

    // Accept an access on the LATENCY=2 instance, then reset one cycle later.
    task automatic rst_mid(input vec_t v, input string nm);
        int cnt;
        @(negedge clk);
        chk({nm, " ready_before"}, 32'(rdy0), 32'd1);
        mw = v.st; addr = v.a; wd = v.wd; sz = v.sz; un = v.un;
        req0 = 1'b1;
        @(posedge clk);
        #1;
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk({nm, " resp_after_rst"}, 32'(rv0), 32'd0);
        chk({nm, " ready_after_rst"}, 32'(rdy0), 32'd1);
        chk({nm, " rdata_after_rst"}, rd0, 32'd0);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rv0) cnt++;
        end
        chk({nm, " no_late_resp"}, 32'(cnt), 32'd0);
    endtask

    initial begin
        vec_t v;
        int cnt;
        logic [8:0] mask;

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; mw = 1'b0; un = 1'b0;
        addr = '0; wd = '0; sz = '0;

        //            st  addr          wdata          sz     un  expected       mis
        vt.push_back('{1, 32'h10,       32'h8000_00FF, 2'b00, 0, 32'h0,         0});
        vt.push_back('{1, 32'h11,       32'h0000_00A5, 2'b10, 0, 32'h0,         0});
        vt.push_back('{0, 32'h10,       32'h0,         2'b00, 0, 32'h8000_A5FF, 0});
        vt.push_back('{0, 32'h11,       32'h0,         2'b10, 0, 32'hFFFF_FFA5, 0});
        vt.push_back('{0, 32'h11,       32'h0,         2'b10, 1, 32'h0000_00A5, 0});
        vt.push_back('{1, 32'h12,       32'h0000_1234, 2'b01, 0, 32'h0,         0});
        vt.push_back('{0, 32'h12,       32'h0,         2'b01, 0, 32'h0000_1234, 0});
        vt.push_back('{1, 32'h12,       32'h0000_8001, 2'b01, 0, 32'h0,         0});
        vt.push_back('{0, 32'h12,       32'h0,         2'b01, 0, 32'hFFFF_8001, 0});
        vt.push_back('{0, 32'h12,       32'h0,         2'b01, 1, 32'h0000_8001, 0});
        vt.push_back('{1, 32'h13,       32'hDEAD_BEEF, 2'b00, 0, 32'h0,         1});
        vt.push_back('{0, 32'h11,       32'h0,         2'b01, 0, 32'h0,         1});
        vt.push_back('{0, 32'h10,       32'h0,         2'b00, 0, 32'h8001_A5FF, 0});
        vt.push_back('{0, 32'h13,       32'h0,         2'b10, 0, 32'hFFFF_FF80, 0});
        vt.push_back('{0, 32'h10,       32'h0,         2'b10, 1, 32'h0000_00FF, 0});
        vt.push_back('{1, 32'h114,      32'h1122_3344, 2'b11, 0, 32'h0,         0});
        vt.push_back('{0, 32'h14,       32'h0,         2'b00, 0, 32'h1122_3344, 0});
        vt.push_back('{0, 32'hFFFF_FF16,32'h0,         2'b01, 1, 32'h0000_1122, 0});
        vt.push_back('{0, 32'h15,       32'h0,         2'b10, 0, 32'h0000_0033, 0});

        vt1.push_back('{1, 32'h04,      32'h55AA_1234, 2'b00, 0, 32'h0,         0});
        vt1.push_back('{0, 32'h04,      32'h0,         2'b00, 0, 32'h55AA_1234, 0});
        vt1.push_back('{0, 32'h05,      32'h0,         2'b10, 0, 32'h0000_0012, 0});
        vt1.push_back('{0, 32'h05,      32'h0,         2'b01, 0, 32'h0,         1});
        vt1.push_back('{0, 32'h106,     32'h0,         2'b01, 0, 32'h0000_55AA, 0});

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst ready0", 32'(rdy0), 32'd1);
        chk("rst resp0", 32'(rv0), 32'd0);
        chk("rst rdata0", rd0, 32'd0);
        chk("rst mis0", 32'(mis0), 32'd0);
        chk("rst ready1", 32'(rdy1), 32'd1);
        chk("rst resp1", 32'(rv1), 32'd0);
        chk("rst rdata1", rd1, 32'd0);
        chk("rst mis1", 32'(mis1), 32'd0);
        rst = 1'b0;

        foreach (vt[i]) acc(1'b0, vt[i], $sformatf("lat2 vec%0d", i));
        foreach (vt1[i]) acc(1'b1, vt1[i], $sformatf("lat1 vec%0d", i));

        // Req held high across busy cycles with WriteData changing every
        // cycle: exactly one acceptance per three cycles, each store taking
        // the data present at its own acceptance edge.
        @(negedge clk);
        chk("held ready_before", 32'(rdy0), 32'd1);
        mw = 1'b1; addr = 32'h20; sz = 2'b10; un = 1'b0; wd = 32'h7E;
        req0 = 1'b1;
        mask = '0;
        cnt = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (rv0) begin
                mask[k-1] = 1'b1;
                cnt++;
            end
            wd = 32'(k);
        end
        req0 = 1'b0;
        chk("held resp_count", 32'(cnt), 32'd3);
        chk("held resp_pattern", 32'(mask), 32'(9'b010010010));
        v = '{0, 32'h20, 32'h0, 2'b10, 1, 32'h0000_0006, 0};
        acc(1'b0, v, "held readback");

        // Reset shortly after acceptance abandons the response but keeps
        // an already committed store.
        v = '{1, 32'h18, 32'hCAFE_F00D, 2'b00, 0, 32'h0, 0};
        rst_mid(v, "rstmid store");
        v = '{0, 32'h10, 32'h0, 2'b00, 0, 32'h0, 0};
        rst_mid(v, "rstmid load");
        v = '{0, 32'h18, 32'h0, 2'b00, 0, 32'hCAFE_F00D, 0};
        acc(1'b0, v, "rstmid readback");
        v = '{0, 32'h10, 32'h0, 2'b00, 0, 32'h8001_A5FF, 0};
        acc(1'b0, v, "mem kept");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
